// File: rtl/memory_cycle.sv
// MEM pipeline stage: drives the data-memory request bus for aligned loads/stores,
// stalls EX while a request is outstanding, and loads the MEM/WB pipeline register.
module memory_cycle #(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Alu_Res,
  input  logic [31:0] StoreData,
  input  logic [4:0]  Rd2,
  input  logic        mem_R,
  input  logic        mem_W,
  input  logic        WB,
  input  logic        RegW,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic [31:0] WB_Data,
  output logic [4:0]  Rd3,
  output logic        RegW_out,
  output logic        err_timeout,
  output logic        err_misalign,
  output logic        state_dbg_o
);

  // Handshake: once dmem_req rises, req/we/addr/wdata stay frozen until the first
  // cycle with dmem_ack=1 (or the timeout); EX holds every input while stall=1.

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  localparam int CW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_q, req_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   wb_data_q, wb_data_d;
  logic [4:0]    rd3_q, rd3_d;
  logic          regw_q, regw_d;
  logic          err_to_q, err_to_d;
  logic          err_ma_q, err_ma_d;
  logic          stall_c;

  logic aligned;
  logic mem_op;
  logic illegal_op;

  assign aligned    = (Alu_Res[1:0] == 2'b00);
  assign mem_op     = (mem_R ^ mem_W) & aligned;
  assign illegal_op = (mem_R & mem_W) | ((mem_R ^ mem_W) & ~aligned);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wb_data_q <= '0;
      rd3_q     <= '0;
      regw_q    <= 1'b0;
      err_to_q  <= 1'b0;
      err_ma_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wb_data_q <= wb_data_d;
      rd3_q     <= rd3_d;
      regw_q    <= regw_d;
      err_to_q  <= err_to_d;
      err_ma_q  <= err_ma_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wb_data_d = wb_data_q;
    rd3_d     = rd3_q;
    regw_d    = regw_q;
    err_to_d  = err_to_q;
    err_ma_d  = err_ma_q;
    stall_c   = 1'b0;

    case (state_q)
      IDLE: begin
        if (illegal_op) begin
          err_ma_d  = 1'b1;
          wb_data_d = '0;
          rd3_d     = '0;
          regw_d    = 1'b0;
        end else if (mem_op) begin
          state_d   = ACCESS;
          cnt_d     = '0;
          req_d     = 1'b1;
          we_d      = mem_W;
          addr_d    = Alu_Res;
          wdata_d   = StoreData;
          wb_data_d = '0;
          rd3_d     = '0;
          regw_d    = 1'b0;
          stall_c   = 1'b1;
        end else begin
          wb_data_d = Alu_Res;
          rd3_d     = Rd2;
          regw_d    = RegW;
        end
      end

      ACCESS: begin
        // Ack wins over a coinciding timeout, so it is tested first.
        if (dmem_ack) begin
          state_d   = IDLE;
          cnt_d     = '0;
          req_d     = 1'b0;
          we_d      = 1'b0;
          wb_data_d = WB ? dmem_rdata : Alu_Res;
          rd3_d     = Rd2;
          regw_d    = RegW;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = IDLE;
          cnt_d     = '0;
          req_d     = 1'b0;
          we_d      = 1'b0;
          err_to_d  = 1'b1;
          wb_data_d = '0;
          rd3_d     = '0;
          regw_d    = 1'b0;
        end else begin
          cnt_d   = cnt_q + CW'(1);
          stall_c = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign stall        = stall_c & ~rst;
  assign dmem_req     = req_q;
  assign dmem_we      = we_q;
  assign dmem_addr    = addr_q;
  assign dmem_wdata   = wdata_q;
  assign WB_Data      = wb_data_q;
  assign Rd3          = rd3_q;
  assign RegW_out     = regw_q;
  assign err_timeout  = err_to_q;
  assign err_misalign = err_ma_q;
  assign state_dbg_o  = state_q;

endmodule

// File: tb/tb_memory_cycle.sv
// Self-checking bench for memory_cycle: MEM/WB results are predicted when an op is
// presented, queued, and compared once the stage releases the op.
module tb_memory_cycle;

  localparam int TO = 15;

  logic        clk;
  logic        rst;
  logic [31:0] Alu_Res;
  logic [31:0] StoreData;
  logic [4:0]  Rd2;
  logic        mem_R;
  logic        mem_W;
  logic        WB;
  logic        RegW;
  logic        stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic [31:0] WB_Data;
  logic [4:0]  Rd3;
  logic        RegW_out;
  logic        err_timeout;
  logic        err_misalign;
  logic        state_dbg;

  // {bubble, WB_Data, Rd3, RegW_out}
  logic [38:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  memory_cycle #(.ACK_TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .Alu_Res      (Alu_Res),
    .StoreData    (StoreData),
    .Rd2          (Rd2),
    .mem_R        (mem_R),
    .mem_W        (mem_W),
    .WB           (WB),
    .RegW         (RegW),
    .stall        (stall),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_rdata   (dmem_rdata),
    .dmem_ack     (dmem_ack),
    .WB_Data      (WB_Data),
    .Rd3          (Rd3),
    .RegW_out     (RegW_out),
    .err_timeout  (err_timeout),
    .err_misalign (err_misalign),
    .state_dbg_o  (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_idle();
    Alu_Res = '0; StoreData = '0; Rd2 = '0;
    mem_R = 1'b0; mem_W = 1'b0; WB = 1'b0; RegW = 1'b0;
    dmem_ack = 1'b0; dmem_rdata = '0;
  endtask

  // Present one op (called at posedge+1) and follow it until stall drops.
  // ack_at: ACCESS cycle (1-based) that sees dmem_ack; 0 = never ack.
  task automatic run_op(input string tag, input logic [31:0] alu, input logic [31:0] sdata,
                        input logic [31:0] rdat, input logic [4:0] rd, input logic r,
                        input logic w, input logic wb, input logic regw, input int ack_at);
    logic        legal_mem, illegal, timed_out;
    logic [38:0] e;
    int          exp_cyc;
    int          stalls = 0;
    int          reqs = 0;
    int          acc = 0;
    bit          done = 1'b0;

    legal_mem = (r ^ w) && (alu[1:0] == 2'b00);
    illegal   = (r & w) || ((r ^ w) && (alu[1:0] != 2'b00));
    timed_out = legal_mem && (ack_at == 0 || ack_at > TO);
    if (illegal || timed_out)   e = {1'b1, 32'h0, 5'h0, 1'b0};
    else if (legal_mem)         e = {1'b0, (wb ? rdat : alu), rd, regw};
    else                        e = {1'b0, alu, rd, regw};
    exp_cyc = !legal_mem ? 0 : (timed_out ? TO : ack_at);
    exp_q.push_back(e);

    Alu_Res = alu; StoreData = sdata; Rd2 = rd;
    mem_R = r; mem_W = w; WB = wb; RegW = regw;

    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      if (acc > 0 && acc == ack_at) begin
        dmem_ack = 1'b1; dmem_rdata = rdat;
      end else begin
        dmem_ack   = (acc == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
        dmem_rdata = $urandom;
      end
      #1;
      if (dmem_req) begin
        reqs++;
        check_eq({tag, "_addr"}, dmem_addr, alu);
        check_eq({tag, "_we"}, dmem_we, w);
        if (w) check_eq({tag, "_wdata"}, dmem_wdata, sdata);
      end
      if (stall) stalls++;
      else done = 1'b1;
      @(posedge clk); #1;
      if (dmem_req) acc++;
    end
    dmem_ack = 1'b0;

    check_eq({tag, "_released"}, done, 1);
    check_eq({tag, "_stall_cycles"}, stalls, exp_cyc);
    check_eq({tag, "_req_cycles"}, reqs, exp_cyc);
    check_eq({tag, "_req_dropped"}, {dmem_req, dmem_we}, 0);

    if (exp_q.size() == 0) begin
      check_eq({tag, "_queue_empty"}, 1, 0);
    end else begin
      e = exp_q.pop_front();
      if (e[38]) check_eq({tag, "_bubble_regw"}, RegW_out, 0);
      else       check_eq({tag, "_memwb"}, {WB_Data, Rd3, RegW_out}, e[37:0]);
    end
  endtask

  initial begin
    drive_idle();
    rst = 1'b1;
    // memory op presented during reset must not raise stall
    mem_R = 1'b1; Alu_Res = 32'h100;
    #1;
    check_eq("rst_stall", stall, 0);
    check_eq("rst_outputs", {dmem_req, dmem_we, dmem_addr, dmem_wdata, WB_Data, Rd3, RegW_out,
                             err_timeout, err_misalign}, 0);
    @(posedge clk); @(posedge clk); #1;
    check_eq("rst_hold_stall", stall, 0);
    rst = 1'b0;
    drive_idle();

    run_op("alu_pass", 32'h0111_1111, 32'h0, 32'h0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    run_op("load_ack3", 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, 3);
    run_op("store_ack1", 32'h0000_0020, 32'h1234_5678, 32'h0, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1);
    run_op("store_regw", 32'h0000_0024, 32'hCAFE_F00D, 32'h0, 5'd4, 1'b0, 1'b1, 1'b0, 1'b1, 1);
    run_op("load_nowb", 32'h0000_0104, 32'h0, 32'h5555_AAAA, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, 2);
    for (int i = 0; i < 4; i++)
      run_op("alu_rand", $urandom, $urandom, $urandom, 5'($urandom_range(0, 31)),
             1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);

    // ack arriving exactly at the timeout boundary completes normally
    run_op("load_ack_last", 32'h0000_0200, 32'h0, 32'h0BAD_F00D, 5'd11, 1'b1, 1'b0, 1'b1, 1'b1, TO);
    check_eq("no_err_timeout", err_timeout, 0);

    run_op("load_timeout", 32'h0000_0300, 32'h0, 32'h0, 5'd12, 1'b1, 1'b0, 1'b1, 1'b1, 0);
    check_eq("err_timeout_set", err_timeout, 1);
    check_eq("err_misalign_clear", err_misalign, 0);

    run_op("misalign_rd", 32'h0000_0003, 32'h0, 32'h0, 5'd13, 1'b1, 1'b0, 1'b1, 1'b1, 1);
    check_eq("err_misalign_set", err_misalign, 1);
    run_op("both_rw", 32'h0000_0040, 32'h0, 32'h0, 5'd14, 1'b1, 1'b1, 1'b1, 1'b1, 1);
    run_op("misalign_wr", 32'h0000_0042, 32'hFFFF_0000, 32'h0, 5'd15, 1'b0, 1'b1, 1'b0, 1'b1, 1);
    run_op("alu_after_err", 32'h7777_0000, 32'h0, 32'h0, 5'd16, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    check_eq("err_sticky", {err_timeout, err_misalign}, 2'b11);

    // reset during the 2nd ACCESS cycle discards the op
    Alu_Res = 32'h0000_0040; Rd2 = 5'd9; mem_R = 1'b1; mem_W = 1'b0; WB = 1'b1; RegW = 1'b1;
    dmem_ack = 1'b0;
    @(posedge clk); #1;
    check_eq("mid_req_acc1", dmem_req, 1);
    @(posedge clk); #1;
    check_eq("mid_req_acc2", dmem_req, 1);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_req", dmem_req, 0);
    check_eq("mid_rst_stall", stall, 0);
    check_eq("mid_rst_outputs", {dmem_we, dmem_addr, dmem_wdata, WB_Data, Rd3, RegW_out,
                                 err_timeout, err_misalign}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive_idle();
    run_op("load_post_rst", 32'h0000_0050, 32'h0, 32'h1357_9BDF, 5'd21, 1'b1, 1'b0, 1'b1, 1'b1, 2);
    run_op("alu_post_rst", 32'h0000_0ABC, 32'h0, 32'h0, 5'd22, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    check_eq("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_cycle.md
MEMORY_CYCLE -- requirements
Module: memory_cycle

Interface
REQ-001 SHALL have parameter ACK_TIMEOUT, default 15, meaning the maximum number of ACCESS cycles to wait for dmem_ack before aborting.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port Alu_Res, input, 32, the EX result, used as the memory address or pass-through result.
REQ-005 SHALL have port StoreData, input, 32, the store data for writes.
REQ-006 SHALL have port Rd2, input, 5, the destination register from EX.
REQ-007 SHALL have ports mem_R, mem_W, WB and RegW, each input, 1, the EX control bits; WB=1 selects memory data for write-back.
REQ-008 SHALL have port stall, output, 1, which when high requires EX to hold all inputs through the next edge.
REQ-009 SHALL have ports dmem_req, dmem_we, dmem_addr[31:0] and dmem_wdata[31:0], each output, forming the data-memory request bus.
REQ-010 SHALL have ports dmem_rdata[31:0] and dmem_ack, each input, forming the data-memory response.
REQ-011 SHALL have ports WB_Data[31:0], Rd3[4:0] and RegW_out, each output, forming the MEM/WB pipeline register.
REQ-012 SHALL have ports err_timeout and err_misalign, each output, 1, sticky error flags.

Function
REQ-013 SHALL define a memory op as exactly one of mem_R or mem_W high with Alu_Res[1:0]==0.
REQ-014 SHALL, when mem_R and mem_W are both high, set err_misalign, perform no access, and load a bubble (RegW_out=0).
REQ-015 SHALL, when mem_R^mem_W is high with Alu_Res[1:0]!=0, set err_misalign, perform no access, and load a bubble.
REQ-016 SHALL implement an FSM with states IDLE and ACCESS.
REQ-017 SHALL, in IDLE with a non-memory op, load the MEM/WB register at the edge with WB_Data=Alu_Res, Rd3=Rd2 and RegW_out=RegW, giving 1-cycle latency.
REQ-018 SHALL, in IDLE with a memory op, go to ACCESS at the edge, register dmem_req=1, dmem_we=mem_W, dmem_addr=Alu_Res and dmem_wdata=StoreData, and load a bubble into MEM/WB.
REQ-019 SHALL drive stall = (IDLE and a memory op presented) or (ACCESS and !dmem_ack), combinationally.
REQ-020 SHALL, in ACCESS, hold dmem_req, dmem_we, dmem_addr and dmem_wdata stable until dmem_ack.
REQ-021 SHALL, in ACCESS with dmem_ack=1, clear dmem_req and return to IDLE at the edge.
REQ-022 SHALL, on that same edge, load MEM/WB with WB_Data = (WB ? dmem_rdata : Alu_Res), Rd3=Rd2 and RegW_out=RegW.
REQ-023 SHALL give a minimum memory-op latency of 2 cycles: ack in the first ACCESS cycle.
REQ-024 SHALL ignore dmem_ack while in IDLE.
REQ-025 SHALL, in ACCESS, increment a timeout counter every cycle without ack.
REQ-026 SHALL, when the counter reaches ACK_TIMEOUT, clear dmem_req, set err_timeout, load a bubble, clear the counter, return to IDLE and deassert stall in that cycle.
REQ-027 SHALL clear the counter on every IDLE->ACCESS transition.
REQ-028 SHALL give ack priority when ack and timeout coincide: normal completion, no error.
REQ-029 SHALL keep err flags high once set until rst.

Reset
REQ-030 SHALL, on rst=1, immediately force state=IDLE and counter=0.
REQ-031 SHALL, on rst=1, force dmem_req, dmem_we, dmem_addr, dmem_wdata, WB_Data, Rd3, RegW_out, err_timeout and err_misalign all to 0.
REQ-032 SHALL, on rst=1, force stall=0 regardless of inputs while rst is high.
REQ-033 SHALL, on reset during ACCESS, drop dmem_req asynchronously and discard the in-flight op with no MEM/WB update.

Verification
REQ-034 SHALL verify ALU pass-through: Alu_Res=0x01111111, Rd2=5, RegW=1, mem_R=mem_W=0 -> next edge WB_Data=0x01111111, Rd3=5, RegW_out=1, stall=0.
REQ-035 SHALL verify load: mem_R=1, WB=1, Alu_Res=0x00000010, ack on the 3rd ACCESS cycle with rdata=0xDEADBEEF -> stall high 3 cycles, dmem_addr=0x10, dmem_we=0, then WB_Data=0xDEADBEEF.
REQ-036 SHALL verify store: mem_W=1, StoreData=0x12345678, Alu_Res=0x20, immediate ack -> dmem_we=1, dmem_wdata=0x12345678 for 1 cycle, total latency 2 cycles, RegW_out=RegW.
REQ-037 SHALL verify timeout: mem_R=1, no ack -> dmem_req drops after 15 ACCESS cycles, err_timeout=1, RegW_out=0, stall=0.
REQ-038 SHALL verify misalign/illegal: Alu_Res=0x3 with mem_R=1, then mem_R=mem_W=1 -> no dmem_req, err_misalign=1, bubbles loaded.
REQ-039 SHALL verify reset mid-ACCESS: rst pulsed during the 2nd ACCESS cycle -> dmem_req=0 immediately, all outputs 0, next op proceeds normally.
